fetch_align_buffer: RTL
=======================

// Module: fetch_align_buffer
//
// PURPOSE
// - Parametrised instruction fetch buffer between the fetch port and decode.
// - Stores fetched 16-bit parcels with their PCs in a circular queue.
// - Realigns mixed RVC (16-bit) and 32-bit instructions, including those
//   straddling fetch words.
// - Presents up to ISSUE aligned instructions per cycle.
// - Valid/ready on both sides; flush with half-word entry alignment on redirect.
//
// PARAMETERS
// DEPTH     16  queue entries (16-bit parcels); power of 2, >= 2*FETCH_HW
// FETCH_HW  2   parcels per fetch beat (2 = 32-bit, 4 = 64-bit fetch)
// ISSUE     2   output slots per cycle (1 or 2)
//
// PORTS
// clock      in   1            rising-edge clock
// reset      in   1            synchronous, active-high
// clear      in   1            flush (branch/trap redirect)
// clear_skip in   1            with clear: drop parcel 0 of next accepted beat
// in_valid   in   1            fetch beat valid
// in_pc      in   32           PC of parcel 0 of beat (parcel k at in_pc+2k)
// in_data    in   16*FETCH_HW  beat data, parcel 0 in LSBs
// in_ready   out  1            beat accepted when in_valid & in_ready
// out_valid  out  ISSUE        slot i holds a complete instruction
// out_pc     out  32*ISSUE     slot PCs (0 when slot invalid)
// out_instr  out  32*ISSUE     slot instr; RVC zero-extended (0 when invalid)
// out_comp   out  ISSUE        slot instruction is 16-bit
// out_ready  in   1            consumer takes ALL valid slots this cycle
// count      out  clog2(DEPTH)+1  parcels held (debug/perf)
//
// BEHAVIOUR
// - State: wptr, rptr (clog2(DEPTH) bits, wrap mod DEPTH), count, skip flag.
// - Storage: DEPTH x 48-bit entries {pc[31:0], parcel[15:0]}.
// - Reset (clock edge with reset=1):
//   - count=0, wptr=rptr=0, skip=0.
//   - Storage need not be cleared.
//   - While reset=1: in_ready=0, out_valid=0, out_pc=out_instr=0, out_comp=0.
// - in_ready = !reset & !clear & (DEPTH - count >= FETCH_HW); uses registered count.
// - Push (in_valid & in_ready):
//   - Write FETCH_HW parcels at wptr..wptr+FETCH_HW-1, PCs in_pc+2k.
//   - If skip=1: parcel 0 is not written, only FETCH_HW-1 parcels are
//     pushed, and skip clears.
// - Decode (combinational from registered state; data visible the cycle
//   after push):
//   - Slot0 at rptr: comp = (parcel[1:0] != 2'b11); needs 1 parcel if comp, else 2.
//   - Slot0 valid iff count >= needed.
//   - 32-bit instr = {parcel[rptr+1], parcel[rptr]}; pc = pc of rptr entry.
//   - Slot1 (ISSUE=2) starts at rptr + len0 and uses the same rule.
//   - Slot1 valid only if slot0 valid and count >= len0 + len1.
// - Pop (out_ready & out_valid[0]):
//   - rptr += sum of len of valid slots.
//   - out_ready with no valid slot is a no-op.
// - Simultaneous push and pop: count_next = count + pushed - popped.
//   Never exceeds DEPTH; never underflows.
// - Clear (priority over push, pop and everything except reset):
//   - count=0, wptr=rptr=0, skip=clear_skip.
//   - in_valid beat in the clear cycle is dropped.
//   - Outputs in the clear cycle still reflect pre-clear state but out_ready
//     is ignored (nothing consumed).
// - Partial 32-bit instruction (count=1, parcel[1:0]=11): held, out_valid=0
//   until its upper parcel arrives; may straddle the wptr/rptr wrap point.
// - Throughput: one beat in and ISSUE instructions out per cycle, sustained,
//   when not full.
//
// TESTING
// 1. reset=1 3 cycles, release -> in_ready=1, out_valid=0, count=0.
// 2. FETCH_HW=2, ISSUE=2: push pc=0x100 data=0x4501_4581 (two RVC) ->
//    next cycle out_valid=2'b11, out_pc={0x102,0x100},
//    out_instr={0x4501,0x4581}, out_comp=2'b11.
// 3. Straddle: push pc=0x200 data=0x0513_4581, hold out_ready=0 ->
//    slot0 RVC 0x4581, slot1 invalid (1 parcel of a 32-bit instr).
//    Push pc=0x204 data=0x4501_0000 -> slot1 pc=0x202, instr=0x00000513.
// 4. clear=1, clear_skip=1, then push pc=0x300 data=0x4581_FFFF ->
//    count=1, out_valid[0]=1, out_pc[0]=0x302, out_instr[0]=0x4581.
// 5. DEPTH=16, out_ready=0, push 8 beats -> count=16, in_ready=0.
//    out_ready=1 for one cycle with two valid slots -> in_ready=1 next cycle.
//    No data lost across wrap.
// 6. clear together with in_valid and out_ready -> next cycle count=0,
//    out_valid=0; the beat presented with clear is dropped and nothing is
//    consumed.

Source files
------------

// File: rtl/fetch_align_buffer.sv
// ---------------------------------------------------------------------------
// fetch_align_buffer
//
// Instruction fetch buffer sitting between the fetch port and decode. Fetch
// beats of FETCH_HW 16-bit parcels are stored, each parcel with its own PC,
// in a circular queue. Decode sees up to ISSUE realigned instructions per
// cycle, mixing 16-bit (RVC) and 32-bit encodings. A 32-bit instruction may
// straddle two fetch beats and/or the physical wrap point of the queue.
//
// Parameters
//   DEPTH     queue entries (16-bit parcels); power of 2, >= 2*FETCH_HW
//   FETCH_HW  parcels per fetch beat
//   ISSUE     output slots per cycle (1 or 2)
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_clear        flush on redirect; wins over push and pop
//   i_clear_skip   with i_clear: drop parcel 0 of the next accepted beat
//   i_in_valid     fetch beat valid
//   i_in_pc        PC of parcel 0 of the beat (parcel k at i_in_pc + 2k)
//   i_in_data      beat data, parcel 0 in the LSBs
//   o_in_ready     beat accepted when i_in_valid & o_in_ready
//   o_out_valid    per-slot: slot holds a complete instruction
//   o_out_pc       per-slot PC, 32 bits each (0 when slot invalid)
//   o_out_instr    per-slot instruction, RVC zero-extended (0 when invalid)
//   o_out_comp     per-slot: instruction is 16-bit
//   i_out_ready    consumer takes every valid slot this cycle
//   o_count        parcels currently held
// ---------------------------------------------------------------------------
module fetch_align_buffer #(
    parameter int DEPTH    = 16,
    parameter int FETCH_HW = 2,
    parameter int ISSUE    = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_clear_skip,
    input  logic                      i_in_valid,
    input  logic [31:0]               i_in_pc,
    input  logic [16*FETCH_HW-1:0]    i_in_data,
    output logic                      o_in_ready,
    output logic [ISSUE-1:0]          o_out_valid,
    output logic [32*ISSUE-1:0]       o_out_pc,
    output logic [32*ISSUE-1:0]       o_out_instr,
    output logic [ISSUE-1:0]          o_out_comp,
    input  logic                      i_out_ready,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Parcel storage; each entry carries its own PC so that a skipped
    // parcel 0 or a redirect never needs PC arithmetic on the read side.
    logic [31:0]   r_mem_pc     [DEPTH];
    logic [15:0]   r_mem_parcel [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_skip;

    logic [CW-1:0] w_free;
    logic          w_push;
    logic [CW-1:0] w_push_n;
    logic          w_pop;
    logic [CW-1:0] w_pop_n;
    logic [CW-1:0] w_used;
    logic [ISSUE-1:0] w_slot_valid;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    assign w_free     = CW'(DEPTH) - r_count;
    assign o_in_ready = !i_reset && !i_clear && (w_free >= CW'(FETCH_HW));
    assign w_push     = i_in_valid && o_in_ready;

    // A pending skip drops parcel 0, so one fewer parcel enters the queue.
    always_comb begin
        w_push_n = '0;
        if (w_push) begin
            w_push_n = r_skip ? CW'(FETCH_HW - 1) : CW'(FETCH_HW);
        end
    end

    // Storage is never reset; r_count alone decides which entries are live.
    // With skip pending, parcel k lands at wptr+k-1 so the beat stays packed.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            for (int k = 0; k < FETCH_HW; k++) begin
                if (!(r_skip && (k == 0))) begin
                    r_mem_parcel[r_wptr + AW'(k) - AW'(r_skip)] <= i_in_data[16*k +: 16];
                    r_mem_pc[r_wptr + AW'(k) - AW'(r_skip)]     <= i_in_pc + 32'(2*k);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode / realignment
    //
    // Slots are walked in order from rptr. A slot is valid only if every
    // earlier slot is valid and enough parcels are held to cover it, so a
    // lone lower half of a 32-bit instruction stays invisible until its
    // upper half arrives. w_used ends up as the parcel total of all valid
    // slots, which is exactly what a pop retires.
    // ------------------------------------------------------------------
    always_comb begin
        logic [AW-1:0] w_ptr;
        logic [CW-1:0] w_len;
        logic [CW-1:0] w_need;
        logic [15:0]   w_lo;
        logic [15:0]   w_hi;
        logic          w_c;
        logic          w_ok;

        w_ptr        = r_rptr;
        w_len        = '0;
        w_need       = '0;
        w_lo         = '0;
        w_hi         = '0;
        w_c          = 1'b0;
        w_ok         = !i_reset;
        w_used       = '0;
        w_slot_valid = '0;
        o_out_comp   = '0;
        o_out_pc     = '0;
        o_out_instr  = '0;

        for (int s = 0; s < ISSUE; s++) begin
            w_lo   = r_mem_parcel[w_ptr];
            w_hi   = r_mem_parcel[w_ptr + AW'(1)];
            w_c    = (w_lo[1:0] != 2'b11);
            w_len  = w_c ? CW'(1) : CW'(2);
            w_need = w_used + w_len;
            w_ok   = w_ok && (r_count >= w_need);
            if (w_ok) begin
                w_slot_valid[s]        = 1'b1;
                o_out_comp[s]          = w_c;
                o_out_pc[32*s +: 32]   = r_mem_pc[w_ptr];
                o_out_instr[32*s +: 32] = w_c ? {16'h0000, w_lo} : {w_hi, w_lo};
                w_used                 = w_need;
            end
            w_ptr = w_ptr + w_len[AW-1:0];
        end
    end

    assign o_out_valid = w_slot_valid;

    // ------------------------------------------------------------------
    // Output side: a clear cycle still shows the old slots but consumes
    // nothing.
    // ------------------------------------------------------------------
    assign w_pop   = i_out_ready && w_slot_valid[0] && !i_clear;
    assign w_pop_n = w_pop ? w_used : '0;

    // ------------------------------------------------------------------
    // Pointer / occupancy state
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_skip  <= 1'b0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_skip  <= i_clear_skip;
        end else begin
            r_wptr  <= r_wptr + w_push_n[AW-1:0];
            r_rptr  <= r_rptr + w_pop_n[AW-1:0];
            r_count <= r_count + w_push_n - w_pop_n;
            if (w_push) begin
                r_skip <= 1'b0;
            end
        end
    end

    assign o_count = r_count;

endmodule
